// File: rtl/hazard_ctrl_mc_pkg.sv
// Shared types for the multi-cycle hazard controller: FSM states, forward codes
// and the bundle of stall/flush controls driven into the pipeline registers.
package hazard_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MDBUSY  = 2'd1,
        DRAIN   = 2'd2,
        SYSCALL = 2'd3
    } hzState_t;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    // E, M and W must empty before the syscall is serviced
    localparam int DRAIN_CYCLES = 3;

    typedef struct packed {
        logic stallF;
        logic stallD;
        logic stallE;
        logic flushD;
        logic flushE;
        logic flushM;
    } hzCtrl_t;

endpackage

// File: rtl/hazard_ctrl_mc_forward_select.sv
// Forwarding source selection for one register operand; M beats W, and
// register 0 is never forwarded.
module forward_select
    import hazard_pkg::*;
#(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] srcId,
    input  logic [REG_W-1:0] writeRegM,
    input  logic             regWriteM,
    input  logic [REG_W-1:0] writeRegW,
    input  logic             regWriteW,
    output logic [1:0]       fwd
);

    always_comb begin
        fwd = FWD_RF;
        if (srcId != '0) begin
            if (regWriteM && (writeRegM == srcId))
                fwd = FWD_M;
            else if (regWriteW && (writeRegW == srcId))
                fwd = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the F/D/E/M/W pipeline: forwarding, load/branch stalls,
// multi-cycle execute hold and a syscall drain/service handshake.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int REG_W        = 5,
    parameter int MULDIV_LAT   = 4,
    parameter int EARLY_BRANCH = 1,
    parameter int CNT_W        = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic             BranchD,
    input  logic             syscallD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic             MemtoRegE,
    input  logic             RegWriteE,
    input  logic             MultiE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic             MemtoRegM,
    input  logic             RegWriteM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteW,
    input  logic             syscall_done,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             syscall_go,
    output logic [CNT_W-1:0] busy_count
);

    localparam bit EB       = (EARLY_BRANCH != 0);
    localparam bit MULTI_EN = (MULDIV_LAT > 1);
    localparam logic [CNT_W-1:0] MD_INIT    = CNT_W'((MULDIV_LAT > 1) ? MULDIV_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

    hzState_t         state, nextState;
    logic [CNT_W-1:0] cnt, nextCnt;
    logic             goReg;
    logic             lwStall, brStall, multiStart;
    hzCtrl_t          ctrl;
    logic [1:0]       fwdAE, fwdBE, fwdAD, fwdBD;

    forward_select #(.REG_W(REG_W)) uFwdAE (
        .srcId(RsE), .writeRegM(WriteRegM), .regWriteM(RegWriteM),
        .writeRegW(WriteRegW), .regWriteW(RegWriteW), .fwd(fwdAE));
    forward_select #(.REG_W(REG_W)) uFwdBE (
        .srcId(RtE), .writeRegM(WriteRegM), .regWriteM(RegWriteM),
        .writeRegW(WriteRegW), .regWriteW(RegWriteW), .fwd(fwdBE));
    // Decode-stage compare only ever sees ALUOutM, so the W path is tied off
    forward_select #(.REG_W(REG_W)) uFwdAD (
        .srcId(RsD), .writeRegM(WriteRegM), .regWriteM(RegWriteM && EB),
        .writeRegW('0), .regWriteW(1'b0), .fwd(fwdAD));
    forward_select #(.REG_W(REG_W)) uFwdBD (
        .srcId(RtD), .writeRegM(WriteRegM), .regWriteM(RegWriteM && EB),
        .writeRegW('0), .regWriteW(1'b0), .fwd(fwdBD));

    assign lwStall = MemtoRegE && (RtE != '0) && ((RtE == RsD) || (RtE == RtD));
    assign brStall = EB && BranchD &&
        ((RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
         (MemtoRegM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))));
    assign multiStart = MultiE && MULTI_EN;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            goReg <= 1'b0;
        end else begin
            state <= nextState;
            cnt   <= nextCnt;
            goReg <= (state == DRAIN) && (cnt == '0);
        end
    end

    always_comb begin
        nextState = state;
        nextCnt   = cnt;
        case (state)
            IDLE: begin
                if (multiStart) begin
                    nextState = MDBUSY;
                    nextCnt   = MD_INIT;
                end else if (!(lwStall || brStall) && syscallD) begin
                    nextState = DRAIN;
                    nextCnt   = DRAIN_INIT;
                end
            end
            MDBUSY:  if (cnt != '0) nextCnt = cnt - 1'b1; else nextState = IDLE;
            DRAIN:   if (cnt == '0) nextState = SYSCALL; else nextCnt = cnt - 1'b1;
            SYSCALL: if (syscall_done) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        ctrl = '0;
        if (reset) begin
            ctrl.flushD = 1'b1;
            ctrl.flushE = 1'b1;
            ctrl.flushM = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (multiStart) begin
                        ctrl.stallF = 1'b1; ctrl.stallD = 1'b1;
                        ctrl.stallE = 1'b1; ctrl.flushM = 1'b1;
                    end else if (lwStall || brStall || syscallD) begin
                        ctrl.stallF = 1'b1; ctrl.stallD = 1'b1; ctrl.flushE = 1'b1;
                    end else begin
                        ctrl.flushD = BranchD;
                    end
                end
                MDBUSY: begin
                    if (cnt != '0) begin
                        ctrl.stallF = 1'b1; ctrl.stallD = 1'b1;
                        ctrl.stallE = 1'b1; ctrl.flushM = 1'b1;
                    end else begin
                        ctrl.flushD = BranchD;
                    end
                end
                DRAIN: begin
                    ctrl.stallF = 1'b1; ctrl.stallD = 1'b1; ctrl.flushE = 1'b1;
                end
                SYSCALL: begin
                    // Completing syscall leaves E as a bubble while fetch resumes
                    ctrl.stallF = !syscall_done;
                    ctrl.stallD = !syscall_done;
                    ctrl.flushE = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

    assign StallF     = ctrl.stallF;
    assign StallD     = ctrl.stallD;
    assign StallE     = ctrl.stallE;
    assign FlushD     = ctrl.flushD;
    assign FlushE     = ctrl.flushE;
    assign FlushM     = ctrl.flushM;
    assign ForwardAE  = reset ? FWD_RF : fwdAE;
    assign ForwardBE  = reset ? FWD_RF : fwdBE;
    assign ForwardAD  = !reset && (fwdAD == FWD_M);
    assign ForwardBD  = !reset && (fwdBD == FWD_M);
    assign syscall_go = goReg && !reset;
    assign busy_count = (!reset && ((state == MDBUSY) || (state == DRAIN))) ? cnt : '0;

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Bench for hazard_ctrl_mc: two instances (LAT=4/early branch, LAT=1/no early
// branch) on shared stimulus, checked every cycle against a counter-based model.
module tb_hazard_ctrl_mc;
    localparam int REG_W = 5;
    localparam int CNT_W = 3;

    logic clock = 1'b0;
    logic reset;
    logic [REG_W-1:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic BranchD, syscallD, MemtoRegE, RegWriteE, MultiE, MemtoRegM, RegWriteM, RegWriteW, syscall_done;

    typedef struct packed {
        logic sF, sD, sE, fD, fE, fM;
        logic [1:0] aE, bE;
        logic aD, bD, go;
        logic [CNT_W-1:0] bc;
    } obs_t;

    typedef struct {
        int md;   // remaining multi-cycle hold cycles
        int dr;   // remaining drain cycles
        bit svc;  // waiting for service completion
        bit go;
    } mst_t;

    logic aSF, aSD, aSE, aFD, aFE, aFM, aAD, aBD, aGo;
    logic bSF, bSD, bSE, bFD, bFE, bFM, bAD, bBD, bGo;
    logic [1:0] aAE, aBE, bAE, bBE;
    logic [CNT_W-1:0] aBC, bBC;
    obs_t oA, oB;
    mst_t mA, mB;
    int errors = 0;
    int checks = 0;
    int cycle = 0;

    always #5 clock = ~clock;

    hazard_ctrl_mc #(.REG_W(REG_W), .MULDIV_LAT(4), .EARLY_BRANCH(1), .CNT_W(CNT_W)) dutA (
        .clock(clock), .reset(reset), .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .syscallD(syscallD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
        .MultiE(MultiE), .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .syscall_done(syscall_done),
        .StallF(aSF), .StallD(aSD), .StallE(aSE), .FlushD(aFD), .FlushE(aFE), .FlushM(aFM),
        .ForwardAE(aAE), .ForwardBE(aBE), .ForwardAD(aAD), .ForwardBD(aBD),
        .syscall_go(aGo), .busy_count(aBC));

    hazard_ctrl_mc #(.REG_W(REG_W), .MULDIV_LAT(1), .EARLY_BRANCH(0), .CNT_W(CNT_W)) dutB (
        .clock(clock), .reset(reset), .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .syscallD(syscallD),
        .RsE(RsE), .RtE(RtE), .WriteRegE(WriteRegE), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
        .MultiE(MultiE), .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW), .syscall_done(syscall_done),
        .StallF(bSF), .StallD(bSD), .StallE(bSE), .FlushD(bFD), .FlushE(bFE), .FlushM(bFM),
        .ForwardAE(bAE), .ForwardBE(bBE), .ForwardAD(bAD), .ForwardBD(bBD),
        .syscall_go(bGo), .busy_count(bBC));

    assign oA = {aSF, aSD, aSE, aFD, aFE, aFM, aAE, aBE, aAD, aBD, aGo, aBC};
    assign oB = {bSF, bSD, bSE, bFD, bFE, bFM, bAE, bBE, bAD, bBD, bGo, bBC};

    function automatic logic [1:0] fwdE(logic [REG_W-1:0] id);
        if (id == 0) return 2'b00;
        if (RegWriteM && WriteRegM == id) return 2'b10;
        if (RegWriteW && WriteRegW == id) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit readsD(logic [REG_W-1:0] id);
        return (id != 0) && (id == RsD || id == RtD);
    endfunction

    function automatic bit hazardStall(bit eb);
        bit lw, br;
        lw = MemtoRegE && readsD(RtE) && RtE != 0;
        br = eb && BranchD && ((RegWriteE && readsD(WriteRegE)) || (MemtoRegM && readsD(WriteRegM)));
        return lw || br;
    endfunction

    function automatic obs_t modelOut(int lat, bit eb, mst_t m);
        obs_t e;
        e = '0;
        if (reset) begin
            e.fD = 1'b1; e.fE = 1'b1; e.fM = 1'b1;
            return e;
        end
        e.aE = fwdE(RsE);
        e.bE = fwdE(RtE);
        e.aD = eb && RsD != 0 && RegWriteM && WriteRegM == RsD;
        e.bD = eb && RtD != 0 && RegWriteM && WriteRegM == RtD;
        e.go = m.go;
        if (m.md > 0) begin
            if (m.md > 1) {e.sF, e.sD, e.sE, e.fM} = 4'hF;
            else e.fD = BranchD;
            e.bc = CNT_W'(m.md - 1);
        end else if (m.dr > 0) begin
            {e.sF, e.sD, e.fE} = 3'b111;
            e.bc = CNT_W'(m.dr - 1);
        end else if (m.svc) begin
            e.fE = 1'b1;
            e.sF = !syscall_done;
            e.sD = !syscall_done;
        end else if (MultiE && lat > 1) begin
            {e.sF, e.sD, e.sE, e.fM} = 4'hF;
        end else if (hazardStall(eb) || syscallD) begin
            {e.sF, e.sD, e.fE} = 3'b111;
        end else begin
            e.fD = BranchD;
        end
        return e;
    endfunction

    function automatic mst_t modelNext(int lat, bit eb, mst_t m);
        mst_t n;
        n = m;
        n.go = 1'b0;
        if (reset) begin
            n.md = 0; n.dr = 0; n.svc = 1'b0;
            return n;
        end
        if (m.md > 0) n.md = m.md - 1;
        else if (m.dr > 0) begin
            n.dr = m.dr - 1;
            if (m.dr == 1) begin n.svc = 1'b1; n.go = 1'b1; end
        end else if (m.svc) begin
            if (syscall_done) n.svc = 1'b0;
        end else if (MultiE && lat > 1) n.md = lat - 1;
        else if (!hazardStall(eb) && syscallD) n.dr = 3;
        return n;
    endfunction

    task automatic cmp(string nm, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cycle, act, exp);
        end
    endtask

    task automatic chk(string nm, logic [7:0] act, logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cycle, act, req);
        end
    endtask

    task automatic sample();
        @(negedge clock);
        cmp("modelA", oA, modelOut(4, 1'b1, mA));
        cmp("modelB", oB, modelOut(1, 1'b0, mB));
    endtask

    task automatic advance();
        mA = modelNext(4, 1'b1, mA);
        mB = modelNext(1, 1'b0, mB);
        @(posedge clock);
        #1;
        cycle++;
    endtask

    task automatic clr();
        {RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW} = '0;
        {BranchD, syscallD, MemtoRegE, RegWriteE, MultiE, MemtoRegM, RegWriteM, RegWriteW, syscall_done} = '0;
    endtask

    initial begin
        mA = '{0, 0, 1'b0, 1'b0};
        mB = '{0, 0, 1'b0, 1'b0};
        clr();
        reset = 1'b1;
        sample();
        chk("rst_stallF", 8'(oA.sF), 8'd0);
        chk("rst_flushD", 8'(oA.fD), 8'd1);
        chk("rst_flushM", 8'(oA.fM), 8'd1);
        advance();
        sample(); advance();
        reset = 1'b0;

        RegWriteM = 1; WriteRegM = 3; RegWriteW = 1; WriteRegW = 3; RsE = 3;
        sample(); chk("fwdAE_M", 8'(oA.aE), 8'h2); advance();
        RsE = 0;
        sample(); chk("fwdAE_r0", 8'(oA.aE), 8'h0); advance();
        RsE = 3; RegWriteM = 0;
        sample(); chk("fwdAE_W", 8'(oA.aE), 8'h1); advance();
        clr();

        MemtoRegE = 1; RtE = 5; RsD = 5;
        sample(); chk("lw_stallF", 8'(oA.sF), 8'd1); chk("lw_flushE", 8'(oA.fE), 8'd1); advance();
        clr();
        sample(); chk("lw_after", 8'(oA.sF), 8'd0); advance();

        MultiE = 1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("md_stallE", 8'(oA.sE), 8'(i < 3));
            chk("md_flushM", 8'(oA.fM), 8'(i < 3));
            chk("md_lat1", 8'(oB.sE), 8'd0);
            advance();
        end
        MultiE = 0;

        syscallD = 1;
        sample(); chk("sc_enter", 8'(oA.sF), 8'd1); advance();
        syscallD = 0;
        for (int i = 0; i < 3; i++) begin
            sample(); chk("sc_drain_bc", 8'(oA.bc), 8'(2 - i)); chk("sc_drain_go", 8'(oA.go), 8'd0); advance();
        end
        for (int i = 0; i < 5; i++) begin
            sample(); chk("sc_go", 8'(oA.go), 8'(i == 0)); chk("sc_hold", 8'(oA.sF), 8'd1); advance();
        end
        syscall_done = 1;
        sample(); chk("sc_done_stallF", 8'(oA.sF), 8'd0); chk("sc_done_flushE", 8'(oA.fE), 8'd1); advance();
        syscall_done = 0;
        sample(); chk("sc_idle_flushE", 8'(oA.fE), 8'd0); advance();

        BranchD = 1; RegWriteE = 1; WriteRegE = 7; RsD = 7;
        sample(); chk("br_stall", 8'(oA.sD), 8'd1); chk("br_noeb", 8'(oB.sD), 8'd0); advance();
        RegWriteE = 0; WriteRegE = 0; RegWriteM = 1; WriteRegM = 7;
        sample(); chk("br_fwdAD", 8'(oA.aD), 8'd1); chk("br_flushD", 8'(oA.fD), 8'd1);
        chk("br_fwdAD_noeb", 8'(oB.aD), 8'd0); advance();
        clr();

        MultiE = 1;
        sample(); advance();
        reset = 1;
        sample(); chk("rm_rst_stallE", 8'(oA.sE), 8'd0); advance();
        reset = 0; MultiE = 0;
        sample(); chk("rm_bc", 8'(oA.bc), 8'd0); chk("rm_stallF", 8'(oA.sF), 8'd0);
        chk("rm_go", 8'(oA.go), 8'd0); advance();

        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 79) == 0);
            RsD          = REG_W'($urandom_range(0, 3));
            RtD          = REG_W'($urandom_range(0, 3));
            RsE          = REG_W'($urandom_range(0, 3));
            RtE          = REG_W'($urandom_range(0, 3));
            WriteRegE    = REG_W'($urandom_range(0, 3));
            WriteRegM    = REG_W'($urandom_range(0, 3));
            WriteRegW    = REG_W'($urandom_range(0, 3));
            BranchD      = ($urandom_range(0, 3) == 0);
            syscallD     = ($urandom_range(0, 9) == 0);
            MemtoRegE    = ($urandom_range(0, 3) == 0);
            RegWriteE    = $urandom_range(0, 1) != 0;
            MultiE       = ($urandom_range(0, 7) == 0);
            MemtoRegM    = ($urandom_range(0, 3) == 0);
            RegWriteM    = $urandom_range(0, 1) != 0;
            RegWriteW    = $urandom_range(0, 1) != 0;
            syscall_done = ($urandom_range(0, 3) == 0);
            sample();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
